// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and state type for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          DEF_ADDR_W     = 8;
    localparam int          DEF_DATA_W     = 32;
    localparam logic [31:0] DEF_HALT_INSTR = 32'h0000_0073;
    localparam int          PC_INC         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory and decode-side bundle of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              id_valid;
    logic              id_ready;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_plus4;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
        input  imem_rdata, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
        output imem_rdata, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : Valid/ready output register holding instr, pc and pc+4.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_load,
    input  wire logic              i_flush,
    input  wire logic [DATA_W-1:0] i_instr,
    input  wire logic [ADDR_W-1:0] i_pc,
    output logic                   o_valid,
    output logic      [DATA_W-1:0] o_instr,
    output logic      [ADDR_W-1:0] o_pc,
    output logic      [ADDR_W-1:0] o_pc_plus4
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_plus4;

    // Flush only drops valid; payload is don't-care until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + ADDR_W'(PC_INC);
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage: PC, imem addressing, redirect/flush, halt, count.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [DATA_W-1:0] HALT_INSTR = DEF_HALT_INSTR,
    parameter int                CNT_W      = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              redirect_valid,
    input  wire logic [ADDR_W-1:0] redirect_target,
    instr_fetch_if.master          bus,
    output logic                   halted,
    output logic                   misalign_err,
    output logic      [CNT_W-1:0]  fetch_count
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_count;

    logic              w_id_valid;
    logic              w_capture;
    logic              w_flush;
    logic              w_is_halt;

    assign w_is_halt = (bus.imem_rdata == HALT_INSTR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A redirect in IDLE only loads the PC; start is ignored that cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!redirect_valid && start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_capture && w_is_halt)     w_state_nxt = ST_HALT;
            ST_HALT: if (redirect_valid)             w_state_nxt = ST_RUN;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_flush   = 1'b0;
        if (redirect_valid) begin
            w_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN:  w_capture = !w_id_valid || bus.id_ready;
                default: w_flush   = w_id_valid && bus.id_ready;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else begin
            if (redirect_valid) begin
                r_pc <= {redirect_target[ADDR_W-1:2], 2'b00};
                if (|redirect_target[1:0]) r_misalign <= 1'b1;
            end else if (w_capture) begin
                r_count <= r_count + 1'b1;
                if (!w_is_halt) r_pc <= r_pc + ADDR_W'(PC_INC);
            end
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_capture),
        .i_flush    (w_flush),
        .i_instr    (bus.imem_rdata),
        .i_pc       (r_pc),
        .o_valid    (w_id_valid),
        .o_instr    (bus.id_instr),
        .o_pc       (bus.id_pc),
        .o_pc_plus4 (bus.id_pc_plus4)
    );

    assign bus.id_valid  = w_id_valid;
    assign bus.imem_addr = r_pc;
    assign halted        = (r_state == ST_HALT);
    assign misalign_err  = r_misalign;
    assign fetch_count   = r_count;

endmodule
`default_nettype wire
